// File: rtl/instruction_fetch.sv
// Instruction fetch: one outstanding imem read, 2-entry {instruction, pc} FIFO toward decode,
// with branch redirect that squashes the in-flight response.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          IMEM_LAT_MAX = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [31:0] instruction,
  output logic [31:0] ir_pc
);

  localparam logic [0:0] FETCH   = 1'b0;
  localparam logic [0:0] DISCARD = 1'b1;

  generate
    if (IMEM_LAT_MAX != 1) begin : g_lat_check
      $error("instruction_fetch supports only IMEM_LAT_MAX == 1");
    end
  endgenerate

  logic [0:0]       state;
  logic [31:0]      fetch_pc;
  logic [31:0]      hold_addr;
  logic             pending;
  logic [1:0][31:0] fifo_instr;
  logic [1:0][31:0] fifo_pc;
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;

  logic        req_int;
  logic        ack_v;
  logic        push;
  logic        pop;
  logic [31:0] target;

  // A presented-but-unacked request is latched so address stays frozen across redirects.
  assign req_int   = pending || (state == FETCH && count != 2'd2);
  assign imem_req  = reset_n && req_int;
  assign imem_addr = pending ? hold_addr : fetch_pc;

  assign ir_valid    = reset_n && (count != 2'd0);
  assign instruction = reset_n ? fifo_instr[rd_ptr] : 32'h0;
  assign ir_pc       = reset_n ? fifo_pc[rd_ptr]    : 32'h0;

  assign ack_v  = imem_req && imem_ack;
  assign push   = ack_v && (state == FETCH) && !br_taken;
  assign pop    = ir_valid && ir_ready && !br_taken;
  assign target = br_target & 32'hFFFF_FFFC;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= FETCH;
      fetch_pc   <= RESET_PC;
      hold_addr  <= 32'h0;
      pending    <= 1'b0;
      fifo_instr <= '0;
      fifo_pc    <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
    end else begin
      pending <= imem_req && !imem_ack;
      if (imem_req) hold_addr <= imem_addr;
      if (br_taken) begin
        fetch_pc <= target;
        count    <= 2'd0;
        rd_ptr   <= 1'b0;
        wr_ptr   <= 1'b0;
        state    <= (imem_req && !imem_ack) ? DISCARD : FETCH;
      end else begin
        if (state == DISCARD && ack_v) state <= FETCH;
        if (push) begin
          fifo_instr[wr_ptr] <= imem_rdata;
          fifo_pc[wr_ptr]    <= imem_addr;
          wr_ptr             <= ~wr_ptr;
          fetch_pc           <= imem_addr + 32'd4;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a randomized run
// scored against a program-order model (next delivered pc and its memory word).
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        br_taken;
  logic [31:0] br_target;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] instruction;
  logic [31:0] ir_pc;

  int n_checks = 0;
  int n_fail   = 0;

  instruction_fetch #(.RESET_PC(32'h0000_0000), .IMEM_LAT_MAX(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .br_taken(br_taken), .br_target(br_target),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .instruction(instruction), .ir_pc(ir_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_ack = 1'b0; imem_rdata = 32'h0; br_taken = 1'b0; br_target = 32'h0; ir_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    cyc();
    cyc();
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; br_taken = 1'b1; br_target = 32'h400; ir_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++;
      if ({imem_req, ir_valid, instruction, ir_pc} !== 66'h0) begin
        n_fail++;
        $display("FAIL reset_outputs: req=%b valid=%b instr=%h pc=%h, required all 0",
                 imem_req, ir_valid, instruction, ir_pc);
      end
    end
    idle_inputs();
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_first_req: req=%b addr=%h, required 1/00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_stream();
    do_reset();
    for (int k = 0; k < 9; k++) begin
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin
        n_fail++;
        $display("FAIL stream_addr: req=%b addr=%h, required 1/%h", imem_req, imem_addr, 32'(4 * k));
      end
      if (k > 0) begin
        n_checks++;
        if (ir_valid !== 1'b1 || ir_pc !== 32'(4 * (k - 1)) || instruction !== memf(32'(4 * (k - 1)))) begin
          n_fail++;
          $display("FAIL stream_ir: valid=%b pc=%h instr=%h, required 1/%h/%h",
                   ir_valid, ir_pc, instruction, 32'(4 * (k - 1)), memf(32'(4 * (k - 1))));
        end
      end
      imem_ack = 1'b1; imem_rdata = memf(32'(4 * k)); ir_ready = 1'b1;
      cyc();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ir_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin
        n_fail++;
        $display("FAIL bp_fill: req=%b addr=%h, required 1/%h", imem_req, imem_addr, 32'(4 * k));
      end
      imem_ack = 1'b1; imem_rdata = memf(32'(4 * k));
      cyc();
    end
    // stray ack with no request outstanding must be ignored
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (imem_req !== 1'b0 || ir_valid !== 1'b1 || ir_pc !== 32'h0) begin
        n_fail++;
        $display("FAIL bp_full: req=%b valid=%b pc=%h, required 0/1/00000000", imem_req, ir_valid, ir_pc);
      end
      imem_ack = (k == 0); imem_rdata = 32'hBAD0_BAD0;
      cyc();
    end
    imem_ack = 1'b0; ir_ready = 1'b1;
    cyc();
    n_checks++;
    if (ir_pc !== 32'h4 || instruction !== memf(32'h4) || imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      n_fail++;
      $display("FAIL bp_resume: pc=%h instr=%h req=%b addr=%h, required 00000004/%h/1/00000008",
               ir_pc, instruction, imem_req, imem_addr, memf(32'h4));
    end
    imem_ack = 1'b1; imem_rdata = memf(32'h8);
    cyc();
    n_checks++;
    if (ir_valid !== 1'b1 || ir_pc !== 32'h8 || instruction !== memf(32'h8)) begin
      n_fail++;
      $display("FAIL bp_order: valid=%b pc=%h instr=%h, required 1/00000008/%h", ir_valid, ir_pc, instruction, memf(32'h8));
    end
  endtask

  task automatic test_redirect_outstanding();
    do_reset();
    ir_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      imem_ack = 1'b1; imem_rdata = memf(32'(4 * k));
      cyc();
    end
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      n_fail++;
      $display("FAIL redir_pre: req=%b addr=%h, required 1/00000010", imem_req, imem_addr);
    end
    imem_ack = 1'b0; br_taken = 1'b1; br_target = 32'h100;
    cyc();
    br_taken = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h10 || ir_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL redir_hold: req=%b addr=%h valid=%b, required 1/00000010/0", imem_req, imem_addr, ir_valid);
      end
      imem_ack = (k == 1); imem_rdata = memf(32'h10);
      cyc();
    end
    n_checks++;
    if (ir_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL redir_target: valid=%b req=%b addr=%h, required 0/1/00000100", ir_valid, imem_req, imem_addr);
    end
    imem_ack = 1'b1; imem_rdata = memf(32'h100);
    cyc();
    n_checks++;
    if (ir_valid !== 1'b1 || ir_pc !== 32'h100 || instruction !== memf(32'h100)) begin
      n_fail++;
      $display("FAIL redir_first: valid=%b pc=%h instr=%h, required 1/00000100/%h", ir_valid, ir_pc, instruction, memf(32'h100));
    end
  endtask

  task automatic test_redirect_with_ack();
    do_reset();
    ir_ready = 1'b1;
    imem_ack = 1'b1; imem_rdata = memf(32'h0); br_taken = 1'b1; br_target = 32'h203;
    cyc();
    br_taken = 1'b0;
    n_checks++;
    if (ir_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      n_fail++;
      $display("FAIL brack_next: valid=%b req=%b addr=%h, required 0/1/00000200", ir_valid, imem_req, imem_addr);
    end
    imem_rdata = memf(32'h200);
    cyc();
    n_checks++;
    if (ir_valid !== 1'b1 || ir_pc !== 32'h200 || instruction !== memf(32'h200)) begin
      n_fail++;
      $display("FAIL brack_first: valid=%b pc=%h instr=%h, required 1/00000200/%h", ir_valid, ir_pc, instruction, memf(32'h200));
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_addr [4];
    exp_addr[0] = 32'h0; exp_addr[1] = 32'h0; exp_addr[2] = 32'hFFFF_FFFC; exp_addr[3] = 32'h0;
    do_reset();
    ir_ready = 1'b1;
    br_taken = 1'b1; br_target = 32'hFFFF_FFFC; imem_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp_addr[k]) begin
        n_fail++;
        $display("FAIL wrap_addr: req=%b addr=%h, required 1/%h", imem_req, imem_addr, exp_addr[k]);
      end
      if (k == 3) begin
        n_checks++;
        if (ir_valid !== 1'b1 || ir_pc !== 32'hFFFF_FFFC) begin
          n_fail++;
          $display("FAIL wrap_pc_hi: valid=%b pc=%h, required 1/fffffffc", ir_valid, ir_pc);
        end
      end
      imem_ack = (k > 0); imem_rdata = memf(exp_addr[k]);
      cyc();
      br_taken = 1'b0;
    end
    n_checks++;
    if (ir_valid !== 1'b1 || ir_pc !== 32'h0 || instruction !== memf(32'h0)) begin
      n_fail++;
      $display("FAIL wrap_pc_lo: valid=%b pc=%h instr=%h, required 1/00000000/%h", ir_valid, ir_pc, instruction, memf(32'h0));
    end
  endtask

  task automatic test_reset_midflight();
    // phase 0: FIFO full; phase 1: squash pending (DISCARD)
    for (int ph = 0; ph < 2; ph++) begin
      do_reset();
      ir_ready = (ph == 1);
      imem_ack = 1'b1;
      for (int k = 0; k < 2; k++) begin
        imem_rdata = memf(32'(4 * k));
        cyc();
      end
      if (ph == 1) begin
        imem_ack = 1'b0; br_taken = 1'b1; br_target = 32'h800;
        cyc();
      end
      reset_n = 1'b0; imem_ack = 1'b1; br_taken = 1'b1; br_target = 32'h900;
      cyc();
      n_checks++;
      if (ir_valid !== 1'b0 || imem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_outs(ph%0d): valid=%b req=%b, required 0/0", ph, ir_valid, imem_req);
      end
      idle_inputs();
      reset_n = 1'b1;
      #1;
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 || ir_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_release(ph%0d): req=%b addr=%h valid=%b, required 1/00000000/0", ph, imem_req, imem_addr, ir_valid);
      end
      imem_ack = 1'b1; imem_rdata = memf(32'h0); ir_ready = 1'b1;
      cyc();
      n_checks++;
      if (ir_valid !== 1'b1 || ir_pc !== 32'h0 || instruction !== memf(32'h0)) begin
        n_fail++;
        $display("FAIL midreset_first(ph%0d): valid=%b pc=%h instr=%h, required 1/00000000/%h", ph, ir_valid, ir_pc, instruction, memf(32'h0));
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    logic        prev_hold;
    logic [31:0] prev_addr;
    int          delivered;
    do_reset();
    exp_pc    = 32'h0;
    prev_hold = 1'b0;
    prev_addr = 32'h0;
    delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      ir_ready = ($urandom_range(3) != 0);
      br_taken = ($urandom_range(29) == 0);
      br_target = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      if (prev_hold) begin
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
          n_fail++;
          $display("FAIL rnd_req_stable: req=%b addr=%h, required 1/%h", imem_req, imem_addr, prev_addr);
        end
      end
      if (imem_req === 1'b1 && imem_addr[1:0] !== 2'b00) begin
        n_checks++;
        n_fail++;
        $display("FAIL rnd_addr_align: addr=%h, required low bits 00", imem_addr);
      end
      if (ir_valid === 1'b1 && ir_ready && !br_taken) begin
        n_checks++;
        if (ir_pc !== exp_pc || instruction !== memf(exp_pc)) begin
          n_fail++;
          $display("FAIL rnd_deliver: pc=%h instr=%h, required %h/%h", ir_pc, instruction, exp_pc, memf(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      if (br_taken) exp_pc = br_target & 32'hFFFF_FFFC;
      imem_ack   = ($urandom_range(2) != 0);
      imem_rdata = imem_req ? memf(imem_addr) : $urandom;
      prev_hold  = imem_req && !imem_ack;
      prev_addr  = imem_addr;
      cyc();
    end
    n_checks++;
    if (delivered < 300) begin
      n_fail++;
      $display("FAIL rnd_progress: delivered=%0d, required >= 300", delivered);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_outstanding();
    test_redirect_with_ack();
    test_wrap();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
